// File: rtl/pcs_10g_pkg.sv
// Shared 10GBASE-R PCS definitions: sync headers, scrambler polynomial taps,
// LFSR seed, BER monitor state encoding and the 64-bit descramble helper.
package pcs_10g_pkg;

  localparam int unsigned BLOCK_W   = 66;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned SCR_W     = 58;
  localparam int unsigned BER_CNT_W = 6;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int unsigned SCR_TAP_A = 38;
  localparam int unsigned SCR_TAP_B = 57;

  localparam logic [SCR_W-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    BER_INIT = 2'd0,
    BER_TEST = 2'd1,
    BER_HI   = 2'd2
  } ber_state_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [SCR_W-1:0]     state;
  } descr_res_t;

  function automatic logic sync_hdr_invalid(input logic [1:0] hdr);
    return (hdr != SH_DATA) && (hdr != SH_CTRL);
  endfunction

  // Bit-serial G(x)=1+x^39+x^58, LSB first; the state shifts in received
  // (scrambled) bits, which is what makes it self-synchronizing.
  function automatic descr_res_t descramble(input logic [SCR_W-1:0]     state,
                                            input logic [PAYLOAD_W-1:0] din);
    descr_res_t       r;
    logic [SCR_W-1:0] s;
    r = '0;
    s = state;
    for (int unsigned i = 0; i < PAYLOAD_W; i++) begin
      r.payload[i] = din[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
      s = {s[SCR_W-2:0], din[i]};
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/pcs_10g_descrambler_if.sv
// Receive block bus into and out of the descrambler.
interface pcs_10g_descrambler_if;
  import pcs_10g_pkg::*;

  logic [BLOCK_W-1:0] rx_block_in;
  logic               rx_block_valid;
  logic [BLOCK_W-1:0] rx_block_out;
  logic               rx_block_out_valid;
  logic               sync_hdr_err;

  modport master (
    output rx_block_in,
    output rx_block_valid,
    input  rx_block_out,
    input  rx_block_out_valid,
    input  sync_hdr_err
  );

  modport slave (
    input  rx_block_in,
    input  rx_block_valid,
    output rx_block_out,
    output rx_block_out_valid,
    output sync_hdr_err
  );
endinterface

// File: rtl/pcs_10g_ber_monitor.sv
// BER monitor: windowed invalid-header count driving hi_ber, plus a
// free-running saturating invalid-header counter.
module pcs_10g_ber_monitor
  import pcs_10g_pkg::*;
#(
  parameter int unsigned BER_WINDOW    = 19531,
  parameter int unsigned HI_BER_THRESH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hdr_valid,
  input  logic                 hdr_err,
  input  logic                 block_lock,
  input  logic                 ber_count_clr,
  output logic                 hi_ber,
  output logic [BER_CNT_W-1:0] ber_count
);

  localparam int unsigned TIMER_W = $clog2(BER_WINDOW + 1);
  localparam int unsigned ERR_W   = $clog2(HI_BER_THRESH + 1);

  localparam logic [TIMER_W-1:0]   TIMER_LAST  = TIMER_W'(BER_WINDOW - 1);
  localparam logic [ERR_W-1:0]     ERR_MAX     = ERR_W'(HI_BER_THRESH);
  localparam logic [BER_CNT_W-1:0] BER_CNT_MAX = '1;

  ber_state_e         state;
  logic [TIMER_W-1:0] timer;
  logic [ERR_W-1:0]   err_cnt;
  logic [ERR_W-1:0]   err_cnt_nxt;
  logic               count_err;

  always_comb begin
    count_err   = hdr_valid && hdr_err;
    err_cnt_nxt = err_cnt;
    if (count_err && (err_cnt != ERR_MAX)) begin
      err_cnt_nxt = err_cnt + ERR_W'(1);
    end
  end

  // The expiring block's header is folded into err_cnt_nxt before the
  // window verdict, so a threshold hit on the last block still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BER_INIT;
      timer   <= '0;
      err_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (!block_lock) begin
      state   <= BER_INIT;
      timer   <= '0;
      err_cnt <= '0;
      hi_ber  <= 1'b0;
    end else begin
      case (state)
        BER_INIT: begin
          state <= BER_TEST;
        end
        BER_TEST, BER_HI: begin
          if (hdr_valid) begin
            if (timer == TIMER_LAST) begin
              timer   <= '0;
              err_cnt <= '0;
              if (err_cnt_nxt == ERR_MAX) begin
                state  <= BER_HI;
                hi_ber <= 1'b1;
              end else begin
                state  <= BER_TEST;
                hi_ber <= 1'b0;
              end
            end else begin
              timer   <= timer + TIMER_W'(1);
              err_cnt <= err_cnt_nxt;
              if (err_cnt_nxt == ERR_MAX) begin
                state  <= BER_HI;
                hi_ber <= 1'b1;
              end
            end
          end
        end
        default: begin
          state  <= BER_INIT;
          hi_ber <= 1'b0;
        end
      endcase
    end
  end

  // Lifetime count ignores window expiry and survives loss of lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ber_count <= '0;
    end else if (ber_count_clr) begin
      ber_count <= (block_lock && count_err) ? BER_CNT_W'(1) : '0;
    end else if (block_lock && count_err && (ber_count != BER_CNT_MAX)) begin
      ber_count <= ber_count + BER_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcs_10g_descrambler.sv
// 10GBASE-R receive descrambler with one-cycle registered datapath and
// BER monitoring of the incoming sync headers.
module pcs_10g_descrambler
  import pcs_10g_pkg::*;
#(
  parameter int unsigned BER_WINDOW    = 19531,
  parameter int unsigned HI_BER_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcs_10g_descrambler_if.slave  rx_if,
  input  logic                  block_lock,
  input  logic                  ber_count_clr,
  output logic                  hi_ber,
  output logic [BER_CNT_W-1:0]  ber_count
);

  logic [SCR_W-1:0]   scr_state;
  logic [BLOCK_W-1:0] blk_q;
  logic               vld_q;
  logic               err_q;
  descr_res_t         dres;
  logic [1:0]         hdr;
  logic               hdr_err;

  always_comb begin
    hdr     = rx_if.rx_block_in[BLOCK_W-1:PAYLOAD_W];
    hdr_err = sync_hdr_invalid(hdr);
    dres    = descramble(scr_state, rx_if.rx_block_in[PAYLOAD_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scr_state <= SCR_SEED;
      blk_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      vld_q <= rx_if.rx_block_valid;
      if (rx_if.rx_block_valid) begin
        scr_state <= dres.state;
        blk_q     <= {hdr, dres.payload};
        err_q     <= hdr_err;
      end
    end
  end

  assign rx_if.rx_block_out       = blk_q;
  assign rx_if.rx_block_out_valid = vld_q;
  assign rx_if.sync_hdr_err       = err_q;

  pcs_10g_ber_monitor #(
    .BER_WINDOW    (BER_WINDOW),
    .HI_BER_THRESH (HI_BER_THRESH)
  ) u_ber_monitor (
    .clk           (clk),
    .rst_n         (rst_n),
    .hdr_valid     (rx_if.rx_block_valid),
    .hdr_err       (hdr_err),
    .block_lock    (block_lock),
    .ber_count_clr (ber_count_clr),
    .hi_ber        (hi_ber),
    .ber_count     (ber_count)
  );

endmodule

// File: tb/tb_pcs_10g_descrambler.sv
// Bench for pcs_10g_descrambler: bit-history reference model checked every
// cycle, plus directed scrambler loopback and BER window scenarios.
module tb_pcs_10g_descrambler;

  localparam int WIN = 32;
  localparam int TH  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       block_lock = 1'b0;
  logic       ber_count_clr = 1'b0;
  logic       hi_ber;
  logic [5:0] ber_count;

  pcs_10g_descrambler_if rx_if ();

  pcs_10g_descrambler #(
    .BER_WINDOW    (WIN),
    .HI_BER_THRESH (TH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_if         (rx_if),
    .block_lock    (block_lock),
    .ber_count_clr (ber_count_clr),
    .hi_ber        (hi_ber),
    .ber_count     (ber_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: out bit n = rx[n] ^ rx[n-39] ^ rx[n-58], pre-stream bits = 1.
  bit         dq[$];
  bit         m_vld, m_err, m_hi;
  bit [65:0]  m_blk;
  int         m_cnt, win_blocks, win_errs;
  bit         testing;

  task automatic model_reset();
    dq = {};
    repeat (58) dq.push_back(1'b1);
    m_vld = 0; m_err = 0; m_hi = 0; m_blk = '0; m_cnt = 0;
    win_blocks = 0; win_errs = 0; testing = 0;
  endtask

  task automatic model_step();
    bit [1:0]  h;
    bit [63:0] d, o;
    bit        bad;
    h   = rx_if.rx_block_in[65:64];
    d   = rx_if.rx_block_in[63:0];
    bad = rx_if.rx_block_valid && (h == 2'b00 || h == 2'b11);
    if (ber_count_clr) m_cnt = (block_lock && bad) ? 1 : 0;
    else if (block_lock && bad && m_cnt < 63) m_cnt++;
    if (!block_lock) begin
      testing = 0; win_blocks = 0; win_errs = 0; m_hi = 0;
    end else if (!testing) begin
      testing = 1;
    end else if (rx_if.rx_block_valid) begin
      if (bad && win_errs < TH) win_errs++;
      win_blocks++;
      if (win_errs >= TH) m_hi = 1;
      if (win_blocks == WIN) begin
        m_hi = (win_errs >= TH);
        win_blocks = 0;
        win_errs = 0;
      end
    end
    m_vld = rx_if.rx_block_valid;
    if (rx_if.rx_block_valid) begin
      for (int i = 0; i < 64; i++) begin
        o[i] = d[i] ^ dq[19] ^ dq[0];
        dq.push_back(d[i]);
        void'(dq.pop_front());
      end
      m_blk = {h, o};
      m_err = bad;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model_out_valid", 66'(rx_if.rx_block_out_valid), 66'(m_vld));
        check("model_out_block", rx_if.rx_block_out, m_blk);
        check("model_sync_hdr_err", 66'(rx_if.sync_hdr_err), 66'(m_err));
        check("model_hi_ber", 66'(hi_ber), 66'(m_hi));
        check("model_ber_count", 66'(ber_count), 66'(m_cnt));
      end
    end
  end

  // Transmit-side scrambler: c[n] = d[n] ^ c[n-39] ^ c[n-58].
  bit tq[$];

  task automatic scramble(input bit [63:0] d, output bit [63:0] c);
    for (int i = 0; i < 64; i++) begin
      c[i] = d[i] ^ tq[19] ^ tq[0];
      tq.push_back(c[i]);
      void'(tq.pop_front());
    end
  endtask

  task automatic send(input bit [1:0] h, input bit [63:0] p);
    rx_if.rx_block_in    = {h, p};
    rx_if.rx_block_valid = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    rx_if.rx_block_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  int bad_ctr = 0;
  task automatic send_n(input int n, input bit bad);
    for (int i = 0; i < n; i++) begin
      if (bad) begin
        send(bad_ctr[0] ? 2'b11 : 2'b00, {$urandom, $urandom});
        bad_ctr++;
      end else begin
        send(2'b01, {$urandom, $urandom});
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [63:0] data, scr;
    bit [1:0]  h;
    rx_if.rx_block_in    = '0;
    rx_if.rx_block_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset_out_block", rx_if.rx_block_out, 66'h0);
    check("reset_out_valid", 66'(rx_if.rx_block_out_valid), 66'h0);
    check("reset_sync_hdr_err", 66'(rx_if.sync_hdr_err), 66'h0);
    check("reset_hi_ber", 66'(hi_ber), 66'h0);
    check("reset_ber_count", 66'(ber_count), 66'h0);
    idle();
    check("reset_idle_valid", 66'(rx_if.rx_block_out_valid), 66'h0);

    // Zero payload against the all-ones seed: bits 39..57 come out set.
    send(2'b01, 64'h0);
    check("pin_first_block", rx_if.rx_block_out, {2'b01, 64'h03FF_FF80_0000_0000});
    check("pin_first_valid", 66'(rx_if.rx_block_out_valid), 66'h1);
    send(2'b01, 64'h0);
    check("pin_second_block", rx_if.rx_block_out, {2'b01, 64'h0});
    idle();
    check("pin_gap_valid", 66'(rx_if.rx_block_out_valid), 66'h0);
    check("pin_gap_hold", rx_if.rx_block_out, {2'b01, 64'h0});
    send(2'b00, 64'h0);
    check("pin_hdr00_err", 66'(rx_if.sync_hdr_err), 66'h1);
    idle();
    check("pin_hold_err", 66'(rx_if.sync_hdr_err), 66'h1);
    send(2'b11, 64'h0);
    check("pin_hdr11_err", 66'(rx_if.sync_hdr_err), 66'h1);
    send(2'b10, 64'h0);
    check("pin_hdr10_err", 66'(rx_if.sync_hdr_err), 66'h0);
    check("pin_unlocked_ber_count", 66'(ber_count), 66'h0);

    // Loopback with an arbitrary transmit seed and random gaps.
    tq = {};
    repeat (58) tq.push_back(1'($urandom));
    for (int k = 0; k < 1000; k++) begin
      data = {$urandom, $urandom};
      h    = $urandom_range(1) ? 2'b10 : 2'b01;
      scramble(data, scr);
      send(h, scr);
      if (k >= 1) check("loopback_block", rx_if.rx_block_out, {h, data});
      if ($urandom_range(3) == 0) idle();
    end

    // Reset mid-stream with a valid block on the bus.
    rx_if.rx_block_in    = {2'b00, 64'hDEAD_BEEF_0123_4567};
    rx_if.rx_block_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 66'(rx_if.rx_block_out_valid), 66'h0);
    check("midreset_block", rx_if.rx_block_out, 66'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle();
    check("postreset_idle_valid", 66'(rx_if.rx_block_out_valid), 66'h0);

    // BER windows of WIN blocks, threshold TH.
    block_lock = 1'b1;
    idle();
    send_n(15, 1);
    check("w1_15err_hi", 66'(hi_ber), 66'h0);
    send_n(17, 0);
    check("w1_end_hi", 66'(hi_ber), 66'h0);
    check("w1_ber_count", 66'(ber_count), 66'd15);

    send_n(10, 0);
    send_n(15, 1);
    check("w2_15err_hi", 66'(hi_ber), 66'h0);
    send_n(1, 1);
    check("w2_16err_hi", 66'(hi_ber), 66'h1);
    check("w2_ber_count", 66'(ber_count), 66'd31);
    send_n(6, 0);
    check("w2_end_hi", 66'(hi_ber), 66'h1);

    send_n(15, 1);
    send_n(16, 0);
    check("w3_pre_expiry_hi", 66'(hi_ber), 66'h1);
    send_n(1, 1);
    check("w3_expiry_16th_hi", 66'(hi_ber), 66'h1);

    send_n(20, 0);
    repeat (3) idle();
    send_n(11, 0);
    check("w4_31clean_hi", 66'(hi_ber), 66'h1);
    send_n(1, 0);
    check("w4_32clean_hi", 66'(hi_ber), 66'h0);

    send_n(16, 1);
    check("w5_hi", 66'(hi_ber), 66'h1);
    check("w5_ber_count", 66'(ber_count), 66'd63);

    block_lock = 1'b0;
    idle();
    check("unlock_hi", 66'(hi_ber), 66'h0);
    check("unlock_ber_count", 66'(ber_count), 66'd63);

    ber_count_clr = 1'b1;
    idle();
    ber_count_clr = 1'b0;
    check("clear_ber_count", 66'(ber_count), 66'd0);

    block_lock = 1'b1;
    send_n(70, 1);
    check("sat_ber_count", 66'(ber_count), 66'd63);
    ber_count_clr = 1'b1;
    send_n(1, 1);
    ber_count_clr = 1'b0;
    check("clear_with_err", 66'(ber_count), 66'd1);
    ber_count_clr = 1'b1;
    send_n(1, 0);
    ber_count_clr = 1'b0;
    check("clear_with_clean", 66'(ber_count), 66'd0);
    idle();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcs_10g_descrambler.md
PCS_10G_DESCRAMBLER -- requirements
Module: pcs_10g_descrambler

Interface
REQ-001 Parameter BER_WINDOW, default 19531: number of valid blocks per BER timer window (125 us at 156.25 Mblock/s).
REQ-002 Parameter HI_BER_THRESH, default 16: count of invalid sync headers per window that asserts hi_ber.
REQ-003 clk  in  1  block clock.
REQ-004 rst_n  in  1  reset: asynchronous, active-low.
REQ-005 rx_block_in  in  66  received block; [65:64] sync header, [63:0] scrambled payload.
REQ-006 rx_block_valid  in  1  rx_block_in qualifier; one block per asserted cycle.
REQ-007 block_lock  in  1  level from the block-lock FSM; 0 holds the BER monitor in INIT.
REQ-008 ber_count_clr  in  1  single-cycle pulse clearing ber_count.
REQ-009 rx_block_out  out  66  descrambled block; header passed through unmodified.
REQ-010 rx_block_out_valid  out  1  rx_block_out qualifier.
REQ-011 sync_hdr_err  out  1  high with rx_block_out_valid when that block's header is 2'b00 or 2'b11.
REQ-012 hi_ber  out  1  high bit-error-rate indication.
REQ-013 ber_count  out  6  saturating count of invalid headers since last clear.

Function
REQ-014 Descrambler SHALL use G(x)=1+x^39+x^58 with a 58-bit state: out[i] = in[i] ^ s[38] ^ s[57], processing i=0..63, then s = {s[56:0], in[i]} (received bit, not output bit).
REQ-015 Descrambler state SHALL advance only on cycles where rx_block_valid=1, whatever block_lock is.
REQ-016 Datapath latency SHALL be 1 cycle: a block valid at edge N appears on rx_block_out with rx_block_out_valid=1 after edge N; rx_block_out_valid=0 after any edge where rx_block_valid=0.
REQ-017 rx_block_out and sync_hdr_err SHALL hold their last value while rx_block_out_valid=0.
REQ-018 Output SHALL equal the original TX payload from the second valid block after any start state, since the descrambler is self-synchronizing after 58 bits.
REQ-019 BER monitor states: INIT, TEST, HI_BER.
REQ-020 block_lock=0 SHALL force INIT from any state: window timer=0, window error count=0, hi_ber=0.
REQ-021 INIT->TEST on the first cycle with block_lock=1.
REQ-022 In TEST/HI_BER, each valid block SHALL increment the window timer; each valid block with an invalid header SHALL increment the window error count, saturating at HI_BER_THRESH.
REQ-023 When the window error count reaches HI_BER_THRESH, the FSM SHALL enter HI_BER and hi_ber SHALL be 1 after that edge.
REQ-024 On the valid block that brings the timer to BER_WINDOW, that block's header SHALL be counted first; then timer=0, error count=0; the FSM goes HI_BER->TEST (hi_ber=0) only if the final count < HI_BER_THRESH, else it stays in HI_BER.
REQ-025 ber_count SHALL increment on every invalid header while block_lock=1, saturate at 63, and be unaffected by window expiry.
REQ-026 ber_count_clr coincident with an increment SHALL yield ber_count=1; clear otherwise yields 0.
REQ-027 Timer and counters SHALL NOT advance on rx_block_valid=0 cycles.

Reset
REQ-028 Reset SHALL set descrambler state to 58'h3FF_FFFF_FFFF_FFFF, rx_block_out=0, rx_block_out_valid=0, sync_hdr_err=0, hi_ber=0, ber_count=0, FSM=INIT, timer=0, window count=0.
REQ-029 Reset asserted mid-stream SHALL take effect immediately; the first post-reset output SHALL be valid no earlier than one cycle after the first post-reset valid input.

Structure
REQ-030 Shared package pcs_10g_pkg SHALL hold the sync-header constants (2'b01 data, 2'b10 control), scrambler tap positions 38/57, the LFSR seed, and the BER FSM state encoding.
REQ-031 BER monitor SHALL be the sub-module pcs_10g_ber_monitor (inputs: hdr_valid, hdr_err, block_lock, ber_count_clr; outputs: hi_ber, ber_count).

Verification (BER_WINDOW=32 for simulation)
REQ-032 Reset check: after rst_n deasserts, every output is 0 and the FSM is in INIT.
REQ-033 Loopback: 1000 random blocks through pcs_10g_scrambler into the DUT -> rx_block_out equals the scrambler input, 1-cycle aligned, from block 2 onward, including with random valid gaps.
REQ-034 16 invalid headers within one 32-block window -> hi_ber=1 one cycle after the 16th; 15 invalid headers -> hi_ber stays 0 and ber_count=15.
REQ-035 HI_BER, then a following window of 32 clean blocks -> hi_ber deasserts after the 32nd; a window with 16 errors, the 16th on the expiry block -> hi_ber stays 1.
REQ-036 block_lock drops while in HI_BER -> hi_ber=0 next cycle while ber_count is retained; 70 invalid headers -> ber_count=63; clear coincident with an error -> ber_count=1.
